// File: rtl/i2c_to_nitta_collector_pkg.sv
// Shared I2C chunking definitions, used by both the collector and the splitter.
package i2c_to_nitta_collector_pkg;

    // Width of one I2C chunk unless the instantiating block overrides it.
    localparam int I2C_DATA_WIDTH_DEFAULT = 8;

    // Number of I2C chunks that make up one NITTA word.
    function automatic int chunk_count(input int data_width, input int i2c_width);
        return data_width / i2c_width;
    endfunction

    // Chunk counter width; a single-chunk word still needs a one-bit counter.
    function automatic int cnt_width(input int chunks);
        return (chunks <= 1) ? 1 : $clog2(chunks);
    endfunction

endpackage

// File: rtl/i2c_to_nitta_collector.sv
// Collects MSB-first I2C chunks into a NITTA word and strobes collector_ready
// for one cycle when a full word is published on to_nitta.
module i2c_to_nitta_collector
    import i2c_to_nitta_collector_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ATTR_WIDTH     = 0,
    parameter int I2C_DATA_WIDTH = I2C_DATA_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i2c_ready,
    input  logic [I2C_DATA_WIDTH-1:0] from_i2c,
    input  logic                      i2c_sync,
    output logic [DATA_WIDTH-1:0]     to_nitta,
    output logic                      collector_ready,
    output logic                      frame_error
);

    localparam int CHUNKS    = chunk_count(DATA_WIDTH, I2C_DATA_WIDTH);
    localparam int CNT_WIDTH = cnt_width(CHUNKS);
    localparam logic [CNT_WIDTH-1:0] LAST_CHUNK = CNT_WIDTH'(CHUNKS - 1);

    // Parameter sanity: partial chunks and attribute ports are not supported.
    if (DATA_WIDTH % I2C_DATA_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of I2C_DATA_WIDTH");
    end
    if (ATTR_WIDTH != 0) begin : g_bad_attr
        $error("ATTR_WIDTH > 0 is not supported");
    end

    logic                  ready_prev;
    logic                  take;
    logic                  complete;
    logic [CNT_WIDTH-1:0]  chunk_cnt;
    logic [CNT_WIDTH-1:0]  cnt_base;
    logic [DATA_WIDTH-1:0] next_word;

    // A chunk is taken only on the rising edge of i2c_ready, so a long level is one chunk.
    assign take = i2c_ready & ~ready_prev;

    // Sync realigns before the chunk in the same cycle is counted, so that chunk is chunk 0.
    assign cnt_base = i2c_sync ? '0 : chunk_cnt;
    assign complete = take & (cnt_base == LAST_CHUNK);

    if (CHUNKS > 1) begin : g_shift
        // Only the older chunks need storage; the newest comes straight from from_i2c.
        logic [DATA_WIDTH-I2C_DATA_WIDTH-1:0] shift_q;

        assign next_word = {shift_q, from_i2c};

        // Shift the accepted chunk in from the LSB end.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                shift_q <= '0;
            end else if (take) begin
                shift_q <= next_word[DATA_WIDTH-I2C_DATA_WIDTH-1:0];
            end
        end
    end else begin : g_single
        assign next_word = from_i2c;
    end

    // Edge history, chunk counter, published word, strobe and sticky framing error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_prev      <= 1'b1;
            chunk_cnt       <= '0;
            to_nitta        <= '0;
            collector_ready <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            ready_prev      <= i2c_ready;
            collector_ready <= complete;

            if (take) begin
                chunk_cnt <= complete ? '0 : cnt_base + 1'b1;
            end else if (i2c_sync) begin
                chunk_cnt <= '0;
            end

            if (complete) begin
                to_nitta <= next_word;
            end

            // A sync landing mid-word wins over a completion; they cannot coincide
            // with a nonzero counter except when the sync itself discards the word.
            if (i2c_sync && (chunk_cnt != '0)) begin
                frame_error <= 1'b1;
            end else if (complete) begin
                frame_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_to_nitta_collector.sv
module tb_i2c_to_nitta_collector;

    logic        clk;
    logic        rst;
    logic        i2c_ready;
    logic [7:0]  from_i2c;
    logic        i2c_sync;
    logic [31:0] to_nitta;
    logic        collector_ready;
    logic        frame_error;

    int total = 0;
    int bad   = 0;

    // reference model: chunks received since the last alignment point
    logic [7:0]  mq[$];
    logic [31:0] m_word;
    logic        m_err;

    i2c_to_nitta_collector #(
        .DATA_WIDTH(32),
        .ATTR_WIDTH(0),
        .I2C_DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i2c_ready(i2c_ready),
        .from_i2c(from_i2c),
        .i2c_sync(i2c_sync),
        .to_nitta(to_nitta),
        .collector_ready(collector_ready),
        .frame_error(frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_word = '0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_sync();
        if (mq.size() != 0) m_err = 1'b1;
        mq.delete();
    endfunction

    // returns 1 when this chunk finishes a word
    function automatic bit model_chunk(input logic [7:0] d);
        logic [31:0] w;
        mq.push_back(d);
        if (mq.size() < 4) return 1'b0;
        w = 0;
        for (int i = 0; i < 4; i++) w = w * 256 + 32'(mq[i]);
        m_word = w;
        m_err  = 1'b0;
        mq.delete();
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_strobe"}, 32'(collector_ready), 32'd0);
        chk({tag, "_word"}, to_nitta, m_word);
        chk({tag, "_err"}, 32'(frame_error), 32'(m_err));
    endtask

    task automatic send_chunk(input logic [7:0] d, input int hold, input int gap, input bit with_sync);
        bit exp_strobe;
        @(negedge clk);
        i2c_ready = 1'b1;
        from_i2c  = d;
        i2c_sync  = with_sync;
        if (with_sync) model_sync();
        exp_strobe = model_chunk(d);
        @(posedge clk); #1;
        chk("take_strobe", 32'(collector_ready), 32'(exp_strobe));
        chk("take_word", to_nitta, m_word);
        chk("take_err", 32'(frame_error), 32'(m_err));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            i2c_sync = 1'b0;
            from_i2c = 8'($urandom);
            @(posedge clk); #1;
            check_idle("hold");
        end
        @(negedge clk);
        i2c_ready = 1'b0;
        i2c_sync  = 1'b0;
        from_i2c  = 8'($urandom);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            check_idle("gap");
        end
    endtask

    task automatic send_sync();
        @(negedge clk);
        i2c_sync = 1'b1;
        model_sync();
        @(posedge clk); #1;
        check_idle("sync");
        @(negedge clk);
        i2c_sync = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int hold);
        logic [31:0] t;
        t = w;
        for (int i = 3; i >= 0; i--) send_chunk(t[i*8 +: 8], hold, 1, 1'b0);
    endtask

    task automatic do_reset(input bit ready_level);
        @(negedge clk);
        rst       = 1'b0;
        i2c_ready = ready_level;
        i2c_sync  = 1'b0;
        model_reset();
        #1;
        chk("rst_word", to_nitta, 32'd0);
        chk("rst_strobe", 32'(collector_ready), 32'd0);
        chk("rst_err", 32'(frame_error), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_idle("in_rst");
        end
        @(negedge clk);
        rst = 1'b1;
        if (ready_level) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check_idle("held_ready");
            end
            @(negedge clk);
            i2c_ready = 1'b0;
            @(posedge clk); #1;
            check_idle("held_drop");
        end
    endtask

    initial begin
        int r;
        rst       = 1'b0;
        i2c_ready = 1'b0;
        from_i2c  = '0;
        i2c_sync  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        // short pulses
        send_word(32'hA0B1C2D3, 1);
        chk("t1_word", to_nitta, 32'hA0B1C2D3);

        // level held for several cycles per chunk
        send_word(32'h0BADF00D, 4);
        chk("t2_word", to_nitta, 32'h0BADF00D);

        // sync mid-word
        send_chunk(8'hA0, 1, 1, 1'b0);
        send_chunk(8'hB1, 1, 1, 1'b0);
        send_sync();
        chk("t3_err_set", 32'(frame_error), 32'd1);
        send_word(32'h11223344, 1);
        chk("t3_word", to_nitta, 32'h11223344);
        chk("t3_err_clr", 32'(frame_error), 32'd0);

        // sync coincident with first chunk, counter already zero
        send_chunk(8'h55, 1, 1, 1'b1);
        send_chunk(8'h66, 1, 1, 1'b0);
        send_chunk(8'h77, 2, 1, 1'b0);
        send_chunk(8'h88, 1, 2, 1'b0);
        chk("t4_word", to_nitta, 32'h55667788);
        chk("t4_err", 32'(frame_error), 32'd0);

        // sync coincident with a chunk while mid-word
        send_chunk(8'h01, 1, 1, 1'b0);
        send_chunk(8'hC0, 1, 1, 1'b1);
        chk("t4b_err", 32'(frame_error), 32'd1);
        send_chunk(8'hC1, 1, 1, 1'b0);
        send_chunk(8'hC2, 1, 1, 1'b0);
        send_chunk(8'hC3, 1, 1, 1'b0);
        chk("t4b_word", to_nitta, 32'hC0C1C2C3);

        // ready held high through reset release
        do_reset(1'b1);
        send_word(32'hA0B1C2D3, 1);
        chk("t5_word", to_nitta, 32'hA0B1C2D3);

        // reset mid-word
        send_chunk(8'hA0, 1, 1, 1'b0);
        send_chunk(8'hB1, 1, 1, 1'b0);
        do_reset(1'b0);
        chk("t6_cleared", to_nitta, 32'd0);
        send_word(32'h01020304, 1);
        chk("t6_word", to_nitta, 32'h01020304);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0)
                send_sync();
            else
                send_chunk(8'($urandom), int'($urandom_range(1, 4)),
                           int'($urandom_range(1, 3)), r == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
